// File: rtl/multi_project_mux_pkg.sv
// Shared types and constants for the multi-project pad/LA multiplexer.
package multi_project_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_RUN   = 2'd2
  } mux_state_e;

  localparam int DEF_N_PROJ    = 8;
  localparam int DEF_IO_W      = 38;
  localparam int DEF_LA_W      = 32;
  localparam int DEF_GUARD_CYC = 4;

  // Per-bit value each bus takes while no project owns the pads.
  localparam logic SAFE_OUT_BIT = 1'b0;
  localparam logic SAFE_OEB_BIT = 1'b1;
  localparam logic SAFE_LA_BIT  = 1'b0;

endpackage

// File: rtl/proj_slice_mux.sv
// One-hot N:1 selector of W-bit slices; any non-one-hot select returns SAFE_BIT on every bit.
module proj_slice_mux
  import multi_project_mux_pkg::*;
#(
  parameter int   N        = DEF_N_PROJ,
  parameter int   W        = DEF_IO_W,
  parameter logic SAFE_BIT = 1'b0
) (
  input  logic [N-1:0]   sel_i,
  input  logic [N*W-1:0] bus_i,
  output logic [W-1:0]   out_o
);

  localparam logic [N-1:0] ONE = N'(1);

  logic onehot;

  always_comb begin
    onehot = (sel_i != '0) && ((sel_i & (sel_i - ONE)) == '0);
    out_o  = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_i[k]) out_o = out_o | bus_i[k*W +: W];
    end
    if (!onehot) out_o = {W{SAFE_BIT}};
  end

endmodule

// File: rtl/multi_project_mux.sv
// Hands the shared pads and LA bus to one project at a time, with a safe-state guard between owners.
// Define MUX_OUTPUT_REG_EN to register io_out_o, io_oeb_o and la_data_out_o (one extra cycle).
module multi_project_mux
  import multi_project_mux_pkg::*;
#(
  parameter int N_PROJ    = DEF_N_PROJ,
  parameter int IO_W      = DEF_IO_W,
  parameter int LA_W      = DEF_LA_W,
  parameter int GUARD_CYC = DEF_GUARD_CYC
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic [N_PROJ-1:0]      active_req_i,
  input  logic [N_PROJ*IO_W-1:0] proj_io_out_i,
  input  logic [N_PROJ*IO_W-1:0] proj_io_oeb_i,
  input  logic [N_PROJ*LA_W-1:0] proj_la_out_i,
  output logic [N_PROJ-1:0]      proj_active_o,
  output logic [IO_W-1:0]        io_out_o,
  output logic [IO_W-1:0]        io_oeb_o,
  output logic [LA_W-1:0]        la_data_out_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam logic [N_PROJ-1:0] ONE        = N_PROJ'(1);
  localparam logic [7:0]        GUARD_LOAD = 8'(GUARD_CYC - 1);

  mux_state_e        state_q, state_d;
  logic [N_PROJ-1:0] req_q, req_d;
  logic [N_PROJ-1:0] tgt_q, tgt_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              req_zero, req_onehot;
  logic [N_PROJ-1:0] mux_sel;
  logic [IO_W-1:0]   io_out_d, io_oeb_d;
  logic [LA_W-1:0]   la_data_d;

  always_comb begin
    req_d      = active_req_i;
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    req_zero   = (req_q == '0);
    req_onehot = !req_zero && ((req_q & (req_q - ONE)) == '0);

    if (req_zero) begin
      // Dropping the request releases the pads at once; tgt is cleared so a
      // later identical request is treated as new and goes through GUARD.
      state_d = ST_IDLE;
      tgt_d   = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (!req_onehot) begin
      err_d = 1'b1;
    end else if (req_q != tgt_q) begin
      state_d = ST_GUARD;
      tgt_d   = req_q;
      cnt_d   = GUARD_LOAD;
    end else if (state_q == ST_GUARD) begin
      if (cnt_q == '0) state_d = ST_RUN;
      else             cnt_d   = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // A zero select drives every slice mux to its safe value.
  assign mux_sel       = (state_q == ST_RUN) ? tgt_q : '0;
  assign proj_active_o = mux_sel;
  assign busy_o        = (state_q == ST_GUARD);
  assign err_o         = err_q;

  proj_slice_mux #(.N(N_PROJ), .W(IO_W), .SAFE_BIT(SAFE_OUT_BIT)) u_mux_io_out (
    .sel_i (mux_sel),
    .bus_i (proj_io_out_i),
    .out_o (io_out_d)
  );

  proj_slice_mux #(.N(N_PROJ), .W(IO_W), .SAFE_BIT(SAFE_OEB_BIT)) u_mux_io_oeb (
    .sel_i (mux_sel),
    .bus_i (proj_io_oeb_i),
    .out_o (io_oeb_d)
  );

  proj_slice_mux #(.N(N_PROJ), .W(LA_W), .SAFE_BIT(SAFE_LA_BIT)) u_mux_la (
    .sel_i (mux_sel),
    .bus_i (proj_la_out_i),
    .out_o (la_data_d)
  );

`ifdef MUX_OUTPUT_REG_EN
  logic [IO_W-1:0] io_out_q, io_oeb_q;
  logic [LA_W-1:0] la_data_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      io_out_q  <= {IO_W{SAFE_OUT_BIT}};
      io_oeb_q  <= {IO_W{SAFE_OEB_BIT}};
      la_data_q <= {LA_W{SAFE_LA_BIT}};
    end else begin
      io_out_q  <= io_out_d;
      io_oeb_q  <= io_oeb_d;
      la_data_q <= la_data_d;
    end
  end

  assign io_out_o      = io_out_q;
  assign io_oeb_o      = io_oeb_q;
  assign la_data_out_o = la_data_q;
`else
  assign io_out_o      = io_out_d;
  assign io_oeb_o      = io_oeb_d;
  assign la_data_out_o = la_data_d;
`endif

endmodule

// File: doc/multi_project_mux.md
MULTI_PROJECT_MUX -- requirements
Module: multi_project_mux

Interface
REQ-001 Parameter N_PROJ, default 8: number of hosted projects, range 2..32.
REQ-002 Parameter IO_W, default 38: GPIO width per project.
REQ-003 Parameter LA_W, default 32: logic-analyser output width per project.
REQ-004 Parameter GUARD_CYC, default 4: safe-state cycles between deselecting one project and enabling the next, range 1..255.
REQ-005 Port wb_clk_i, in, 1: sole clock.
REQ-006 Port wb_rst_n_i, in, 1: asynchronous active-low reset.
REQ-007 Port active_req_i, in, N_PROJ: requested project select from la_data_in, one-hot or zero.
REQ-008 Port proj_io_out_i, in, N_PROJ*IO_W: per-project io_out, project k at bits [k*IO_W +: IO_W].
REQ-009 Port proj_io_oeb_i, in, N_PROJ*IO_W: per-project io_oeb, same packing.
REQ-010 Port proj_la_out_i, in, N_PROJ*LA_W: per-project LA data, same packing.
REQ-011 Port proj_active_o, out, N_PROJ: one-hot enable to the projects.
REQ-012 Port io_out_o, out, IO_W: muxed pad output.
REQ-013 Port io_oeb_o, out, IO_W: muxed pad output enable, active-low.
REQ-014 Port la_data_out_o, out, LA_W: muxed LA data.
REQ-015 Port busy_o, out, 1: high while in GUARD.
REQ-016 Port err_o, out, 1: sticky flag for a multi-hot request.

Function
REQ-017 active_req_i SHALL be registered into req_q every cycle; all decisions SHALL use req_q.
REQ-018 FSM states: IDLE (no project enabled), GUARD (safe hold), RUN (one project enabled).
REQ-019 Safe state, applying in IDLE and GUARD: proj_active_o=0, io_out_o=0, io_oeb_o all 1, la_data_out_o=0.
REQ-020 In RUN, proj_active_o SHALL equal the registered target tgt_q, and outputs SHALL be the slice of the project selected by tgt_q.
REQ-021 When req_q is non-zero one-hot and differs from tgt_q, from IDLE or RUN: next cycle state=GUARD, tgt_q<=req_q, counter<=GUARD_CYC-1.
REQ-022 GUARD SHALL decrement the counter each cycle and enter RUN the cycle after it reaches 0, giving exactly GUARD_CYC cycles of safe state.
REQ-023 A new valid req_q that differs from tgt_q during GUARD SHALL reload tgt_q and the counter, restarting the guard.
REQ-024 When req_q==0, the next state SHALL be IDLE from any state, with no guard period.
REQ-025 When req_q is multi-hot, err_o SHALL be set and the request ignored; state, tgt_q and counter are unchanged.
REQ-026 err_o SHALL clear only on reset or when req_q==0.
REQ-027 An unchanged req_q equal to tgt_q SHALL cause no transition.
REQ-028 End-to-end latency from an active_req_i change to the first RUN cycle SHALL be GUARD_CYC+2 cycles when MUX_OUTPUT_REG_EN is undefined.

Reset
REQ-029 Asserting wb_rst_n_i low SHALL immediately force IDLE, tgt_q=0, req_q=0, counter=0, err_o=0, busy_o=0, and the safe-state outputs, including mid-GUARD and mid-RUN.
REQ-030 After reset release, a held request SHALL be handled as a fresh request, through GUARD.

Configuration
REQ-031 Macro MUX_OUTPUT_REG_EN, defined: io_out_o, io_oeb_o and la_data_out_o SHALL be registered, adding one cycle of latency; the register reset value is the safe state.
REQ-032 Macro MUX_OUTPUT_REG_EN, undefined: those outputs SHALL be combinational from tgt_q and the state.
REQ-033 proj_active_o, busy_o and err_o SHALL be unaffected by the macro.

Structure
REQ-034 Package multi_project_mux_pkg SHALL hold the FSM state enum, the safe-state constants and the default parameter values.
REQ-035 Sub-module proj_slice_mux SHALL implement the parametric one-hot N:1 slice select and be instantiated once per bus: io_out, io_oeb and la.
REQ-036 Any non-one-hot select into proj_slice_mux SHALL yield all zeros for the out and la buses and all ones for oeb.

Verification
REQ-037 Config N_PROJ=4, GUARD_CYC=4, after reset: active_req_i=4'b0010 -> busy_o high 4 cycles, then proj_active_o=4'b0010 and io_out_o equal to the project 1 slice.
REQ-038 From RUN on project 1, switch active_req_i to 4'b1000 -> io_oeb_o all 1 for exactly 4 cycles, then the project 3 slice.
REQ-039 During GUARD toward project 1, at guard cycle 2 switch to 4'b0100 -> guard restarts, total safe cycles 2+4, ending in RUN on project 2.
REQ-040 In RUN on project 1, active_req_i=4'b0110 -> err_o=1 and project 1 stays active; then 4'b0000 -> IDLE and err_o=0.
REQ-041 Assert wb_rst_n_i mid-RUN, asynchronously to the clock -> outputs safe in the same cycle, then re-enter through GUARD after release.
REQ-042 Repeat REQ-037 with MUX_OUTPUT_REG_EN defined -> data appears one cycle later than proj_active_o.
